vec_elem_sequencer: RTL and testbench

Element-serial execution sequencer that sits directly in front of the vector register file. It accepts one vector-vector command at a time and walks element indices 0..vl-1. Per element it drives both register-file read ports, computes the element result in a combinational ALU and writes the result back through the register-file write port one cycle later. It reports completion with a done pulse.

---
 rtl/vec_seq_pkg.sv | 21 ++
 rtl/vec_elem_alu.sv | 33 +++
 rtl/vec_elem_sequencer.sv | 115 +++++++++++
 tb/tb_vec_elem_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/vec_seq_pkg.sv
// Shared encodings for the element-serial vector sequencer: ALU opcodes and FSM states.
package vec_seq_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_AND  = 3'd2,
      OP_OR   = 3'd3,
      OP_XOR  = 3'd4,
      OP_MIN  = 3'd5,
      OP_MAX  = 3'd6,
      OP_PASS = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/vec_elem_alu.sv
// Combinational per-element ALU; a is the vs1 element, b the vs2 element.
module vec_elem_alu
   import vec_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  op_e                   op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] y
);

   logic a_lt_b;

   assign a_lt_b = $signed(a) < $signed(b);

   // NOTE: y gets a default before the case so no path through the block can infer a latch.
   always_comb begin
      y = '0;
      unique case (op)
         OP_ADD:  y = a + b;
         OP_SUB:  y = a - b;
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_MIN:  y = a_lt_b ? a : b;
         OP_MAX:  y = a_lt_b ? b : a;
         OP_PASS: y = a;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/vec_elem_sequencer.sv
// Walks elements 0..vl-1 of one vector-vector command: reads both sources, writes the ALU result one cycle later.
module vec_elem_sequencer
   import vec_seq_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_ELE    = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [2:0]            cmd_op,
   input  logic [ADDR_WIDTH-1:0] cmd_vd,
   input  logic [ADDR_WIDTH-1:0] cmd_vs1,
   input  logic [ADDR_WIDTH-1:0] cmd_vs2,
   input  logic [ADDR_WIDTH:0]   cmd_vl,
   output logic [ADDR_WIDTH-1:0] rf_raddr1_reg,
   output logic [ADDR_WIDTH-1:0] rf_raddr1_ele,
   input  logic [DATA_WIDTH-1:0] rf_rdata1,
   output logic [ADDR_WIDTH-1:0] rf_raddr2_reg,
   output logic [ADDR_WIDTH-1:0] rf_raddr2_ele,
   input  logic [DATA_WIDTH-1:0] rf_rdata2,
   output logic [ADDR_WIDTH-1:0] rf_waddr_reg,
   output logic [ADDR_WIDTH-1:0] rf_waddr_ele,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic                  rf_wen,
   output logic                  busy,
   output logic                  done
);

   localparam logic [ADDR_WIDTH:0] MAX_VL = (ADDR_WIDTH + 1)'(NUM_ELE);

   state_e                state, state_nxt;
   op_e                   op;
   logic [ADDR_WIDTH:0]   eff_vl;
   logic [ADDR_WIDTH:0]   vl_clamped;
   logic [ADDR_WIDTH-1:0] idx;
   logic                  accept;
   logic                  last_ele;
   logic [DATA_WIDTH-1:0] alu_y;

   assign vl_clamped = (cmd_vl > MAX_VL) ? MAX_VL : cmd_vl;
   assign accept     = (state == IDLE) && cmd_valid;
   // The exit test uses idx before it would increment, so idx never has to hold NUM_ELE.
   assign last_ele   = ({1'b0, idx} == eff_vl - 1'b1);

   assign rf_raddr1_ele = idx;
   assign rf_raddr2_ele = idx;

   vec_elem_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
      .op (op),
      .a  (rf_rdata1),
      .b  (rf_rdata2),
      .y  (alu_y)
   );

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (cmd_valid) state_nxt = (vl_clamped == '0) ? DRAIN : RUN;
         RUN:     if (last_ele)  state_nxt = DRAIN;
         DRAIN:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cmd_ready <= (state_nxt == IDLE);
         busy      <= (state_nxt != IDLE);
         done      <= (state_nxt == DRAIN);
      end
   end

   // NOTE: command and writeback registers are reset as well, so every output is 0 out of reset
   // and an asynchronous reset mid-command kills rf_wen at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op            <= OP_ADD;
         eff_vl        <= '0;
         idx           <= '0;
         rf_raddr1_reg <= '0;
         rf_raddr2_reg <= '0;
         rf_waddr_reg  <= '0;
         rf_waddr_ele  <= '0;
         rf_wdata      <= '0;
         rf_wen        <= 1'b0;
      end else begin
         rf_wen <= 1'b0;
         if (accept) begin
            op            <= op_e'(cmd_op);
            eff_vl        <= vl_clamped;
            idx           <= '0;
            rf_raddr1_reg <= cmd_vs1;
            rf_raddr2_reg <= cmd_vs2;
            rf_waddr_reg  <= cmd_vd;
         end
         if (state == RUN) begin
            rf_wen       <= 1'b1;
            rf_wdata     <= alu_y;
            rf_waddr_ele <= idx;
            if (!last_ele) idx <= idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vec_elem_sequencer.sv
// Scoreboard bench: a register-file model feeds the read ports, expected writes and done cycles are queued at issue.
module tb_vec_elem_sequencer;
   import vec_seq_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [4:0]  cmd_vd, cmd_vs1, cmd_vs2;
   logic [5:0]  cmd_vl;
   logic [4:0]  rf_raddr1_reg, rf_raddr1_ele, rf_raddr2_reg, rf_raddr2_ele;
   logic [31:0] rf_rdata1, rf_rdata2;
   logic [4:0]  rf_waddr_reg, rf_waddr_ele;
   logic [31:0] rf_wdata;
   logic        rf_wen, busy, done;

   typedef struct {
      logic [4:0]  rsel;
      logic [4:0]  ele;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   logic [31:0] rf [32][32];
   wr_t         wq[$];
   int          dq[$];
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;

   vec_elem_sequencer dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_vd(cmd_vd), .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2), .cmd_vl(cmd_vl),
      .rf_raddr1_reg(rf_raddr1_reg), .rf_raddr1_ele(rf_raddr1_ele), .rf_rdata1(rf_rdata1),
      .rf_raddr2_reg(rf_raddr2_reg), .rf_raddr2_ele(rf_raddr2_ele), .rf_rdata2(rf_rdata2),
      .rf_waddr_reg(rf_waddr_reg), .rf_waddr_ele(rf_waddr_ele), .rf_wdata(rf_wdata),
      .rf_wen(rf_wen), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign rf_rdata1 = rf[rf_raddr1_reg][rf_raddr1_ele];
   assign rf_rdata2 = rf[rf_raddr2_reg][rf_raddr2_ele];

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] model_alu(input int op, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      sa = int'(a);
      sb = int'(b);
      case (op)
         0: return 32'(sa + sb);
         1: return 32'(sa - sb);
         2: return a & b;
         3: return a | b;
         4: return a ^ b;
         5: return (sa < sb) ? a : b;
         6: return (sa > sb) ? a : b;
         default: return a;
      endcase
   endfunction

   // Write-port and done monitor, sampled on the falling edge; accepted writes update the model.
   always @(negedge clk) begin
      if (!reset) begin
         if (rf_wen) begin
            if (wq.size() == 0) check("spurious_wr", 1, 0);
            else begin
               wr_t e;
               e = wq.pop_front();
               check("wr_reg", rf_waddr_reg, e.rsel);
               check("wr_ele", rf_waddr_ele, e.ele);
               check("wr_data", rf_wdata, e.data);
               check("wr_cyc", cyc, e.cyc);
               rf[rf_waddr_reg][rf_waddr_ele] = rf_wdata;
            end
         end
         if (done) begin
            if (dq.size() == 0) check("spurious_done", 1, 0);
            else check("done_cyc", cyc, dq.pop_front());
         end
      end
   end

   // Drive a command, wait for acceptance, queue expectations for the first `limit` elements.
   task automatic send(input op_e op, input int vd, input int vs1, input int vs2, input int vl,
                       input bit hold, input int limit, output int acc);
      int n, eff;
      cmd_op = op; cmd_vd = 5'(vd); cmd_vs1 = 5'(vs1); cmd_vs2 = 5'(vs2); cmd_vl = 6'(vl);
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (!cmd_ready) check("accept_timeout", 0, 1);
      acc = cyc;
      eff = (vl > 32) ? 32 : vl;
      for (int i = 0; i < eff && i < limit; i++) begin
         wr_t e;
         e.rsel = 5'(vd);
         e.ele  = 5'(i);
         e.data = model_alu(int'(op), rf[vs1][i], rf[vs2][i]);
         e.cyc  = acc + 2 + i;
         wq.push_back(e);
      end
      if (limit >= eff) dq.push_back(acc + eff + 1);
      @(posedge clk); #1;
      if (!hold) cmd_valid = 1'b0;
   endtask

   task automatic wait_ready(input int exp_cyc);
      int n = 0;
      while (!cmd_ready && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (!cmd_ready) check("ready_timeout", 0, 1);
      else check("ready_cyc", cyc, exp_cyc);
   endtask

   initial begin
      int acc, acc_b;
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0;
      cmd_vd = '0; cmd_vs1 = '0; cmd_vs2 = '0; cmd_vl = '0;
      for (int r = 0; r < 32; r++)
         for (int i = 0; i < 32; i++) rf[r][i] = 32'h0;
      for (int i = 0; i < 32; i++) begin
         rf[1][i] = 32'(i);
         rf[2][i] = 32'd10;
      end
      #3;
      check("rst_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_wen", rf_wen, 0);
      check("rst_wdata", rf_wdata, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      send(OP_ADD, 3, 1, 2, 4, 0, 99, acc);
      check("run_busy", busy, 1);
      check("run_ready", cmd_ready, 0);
      wait_ready(acc + 6);

      send(OP_XOR, 9, 1, 2, 0, 0, 99, acc);
      wait_ready(acc + 2);

      send(OP_SUB, 4, 2, 1, 32, 0, 99, acc);
      wait_ready(acc + 34);
      check("sub_last", rf[4][31], 32'hFFFF_FFEB);

      send(OP_AND, 10, 1, 2, 40, 0, 99, acc);
      wait_ready(acc + 34);

      send(OP_ADD, 1, 1, 2, 4, 0, 99, acc);
      wait_ready(acc + 6);
      for (int i = 0; i < 4; i++) check("inplace", rf[1][i], 32'(10 + i));

      rf[5][0] = 32'h8000_0000; rf[6][0] = 32'd5;
      rf[5][1] = 32'h0000_00F0; rf[6][1] = 32'h0000_000F;
      send(OP_MIN, 7, 5, 6, 1, 0, 99, acc);
      wait_ready(acc + 3);
      check("min_neg", rf[7][0], 32'h8000_0000);
      send(OP_MAX, 8, 5, 6, 1, 0, 99, acc);
      wait_ready(acc + 3);
      check("max_neg", rf[8][0], 32'd5);
      send(OP_OR, 13, 5, 6, 2, 0, 99, acc);
      wait_ready(acc + 4);

      send(OP_PASS, 11, 2, 1, 3, 1, 99, acc);
      send(OP_OR, 12, 1, 2, 2, 0, 99, acc_b);
      check("held_accept", acc_b, acc + 5);
      wait_ready(acc_b + 4);

      send(OP_ADD, 14, 1, 2, 8, 0, 2, acc);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk); #1;
      reset = 1'b1;
      #1;
      check("arst_wen", rf_wen, 0);
      check("arst_busy", busy, 0);
      check("arst_ready", cmd_ready, 1);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("post_rst_ready", cmd_ready, 1);
      check("post_rst_busy", busy, 0);
      check("post_rst_e2", rf[14][2], 32'h0);

      check("wq_empty", wq.size(), 0);
      check("dq_empty", dq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
